// File: rtl/parity_mux_stream_if.sv
// Beat-level bus for parity_mux_stream: input beat with valid/ready, registered output beat.
// slave = the block's view, master = the source/sink driving it.
interface parity_mux_stream_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] d;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          y;
  logic                      y_parity;
  logic                      frame_parity;
  logic                      out_last;
  logic [CNT_W-1:0]          word_count;
  logic                      sel_err;

  modport slave (
    input  sel, d, in_valid, in_last, out_ready,
    output in_ready, out_valid, y, y_parity, frame_parity, out_last, word_count, sel_err
  );

  modport master (
    output sel, d, in_valid, in_last, out_ready,
    input  in_ready, out_valid, y, y_parity, frame_parity, out_last, word_count, sel_err
  );
endinterface

// File: rtl/parity_mux_stream.sv
// Registered N:1 word mux with per-beat parity and running per-frame parity/count.
// Define ODD_PARITY_EN to switch y_parity and frame_parity to odd parity.
module parity_mux_stream #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  parity_mux_stream_if.slave   bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int SLOTS = 1 << SEL_W;

  typedef enum logic {IDLE, FRAME} state_e;
  state_e state_q, state_d;

  // Select space padded to a power of two; pad slots flag an illegal select.
  logic [SLOTS-1:0][WIDTH-1:0] slot;
  logic [SLOTS-1:0]            slot_ok;

  genvar k;
  generate
    for (k = 0; k < SLOTS; k++) begin : g_slot
      if (k < CHANNELS) begin : g_ch
        assign slot[k]    = bus.d[k*WIDTH +: WIDTH];
        assign slot_ok[k] = 1'b1;
      end else begin : g_pad
        assign slot[k]    = '0;
        assign slot_ok[k] = 1'b0;
      end
    end
  endgenerate

  logic             accept, sel_ok, raw_par, y_par, acc_d;
  logic [WIDTH-1:0] y_d;
  logic [CNT_W-1:0] cnt_d;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sel_ok       = slot_ok[bus.sel];
  assign y_d          = sel_ok ? slot[bus.sel] : slot[0];
  assign raw_par      = ^y_d;

`ifdef ODD_PARITY_EN
  assign y_par = ~raw_par;
`else
  assign y_par = raw_par;
`endif

  // frame_parity/word_count registers double as the frame accumulators.
  always_comb begin
    state_d = state_q;
    acc_d   = bus.frame_parity;
    cnt_d   = bus.word_count;
    if (accept) begin
      state_d = bus.in_last ? IDLE : FRAME;
      if (state_q == IDLE) begin
        acc_d = y_par;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = bus.frame_parity ^ raw_par;
        cnt_d = (&bus.word_count) ? bus.word_count : bus.word_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid    <= 1'b0;
      bus.y            <= '0;
      bus.y_parity     <= 1'b0;
      bus.frame_parity <= 1'b0;
      bus.out_last     <= 1'b0;
      bus.word_count   <= '0;
      bus.sel_err      <= 1'b0;
    end else if (accept) begin
      bus.out_valid    <= 1'b1;
      bus.y            <= y_d;
      bus.y_parity     <= y_par;
      bus.frame_parity <= acc_d;
      bus.out_last     <= bus.in_last;
      bus.word_count   <= cnt_d;
      bus.sel_err      <= bus.sel_err | ~sel_ok;
    end else if (bus.out_ready) begin
      bus.out_valid    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_parity_mux_stream.sv
// Bench: table vectors, hand sequences (stall, reset, saturation, bad select) and
// random traffic against a frame-level reference model.
module tb_parity_mux_stream;
`ifdef ODD_PARITY_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  parity_mux_stream_if #(.WIDTH(4), .CHANNELS(8), .CNT_W(8)) ia ();
  parity_mux_stream_if #(.WIDTH(4), .CHANNELS(6), .CNT_W(2)) ib ();

  parity_mux_stream #(.WIDTH(4), .CHANNELS(8), .CNT_W(8)) u_a (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
  parity_mux_stream #(.WIDTH(4), .CHANNELS(6), .CNT_W(2)) u_b (.clk(clk), .reset_n(reset_n), .bus(ib.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words of the open frame plus the expected output register.
  logic [3:0] frame_q[$];
  bit         m_open;
  logic       m_valid, m_yp, m_fp, m_last;
  logic [3:0] m_y;
  int         m_wc;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] word;
    logic       last;
    logic [3:0] y;
    logic       yp;
    logic       fp;
    int         wc;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fold_par();
    logic p = ODD;
    foreach (frame_q[i]) p ^= ^frame_q[i];
    return p;
  endfunction

  task automatic model_reset();
    frame_q.delete();
    m_open = 0; m_valid = 0; m_yp = 0; m_fp = 0; m_last = 0; m_y = 0; m_wc = 0;
  endtask

  // One clock of DUT a: drive after negedge, check in_ready, model at posedge, check at next negedge.
  task automatic cyc(input logic [2:0] s, input logic [31:0] dd, input logic v, input logic l, input logic o);
    logic rdy;
    logic [3:0] w;
    ia.sel = s; ia.d = dd; ia.in_valid = v; ia.in_last = l; ia.out_ready = o;
    #1;
    rdy = !m_valid || o;
    chk("in_ready", {31'd0, ia.in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (v && rdy) begin
      w = dd[int'(s)*4 +: 4];
      if (!m_open) frame_q.delete();
      frame_q.push_back(w);
      m_open  = !l;
      m_y     = w;
      m_yp    = (^w) ^ ODD;
      m_fp    = fold_par();
      m_wc    = (frame_q.size() > 255) ? 255 : frame_q.size();
      m_last  = l;
      m_valid = 1'b1;
    end else if (o) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("out_valid",    {31'd0, ia.out_valid},    {31'd0, m_valid});
    chk("y",            {28'd0, ia.y},            {28'd0, m_y});
    chk("y_parity",     {31'd0, ia.y_parity},     {31'd0, m_yp});
    chk("frame_parity", {31'd0, ia.frame_parity}, {31'd0, m_fp});
    chk("out_last",     {31'd0, ia.out_last},     {31'd0, m_last});
    chk("word_count",   {24'd0, ia.word_count},   m_wc);
    chk("sel_err_a",    {31'd0, ia.sel_err},      32'd0);
  endtask

  // One beat into DUT b (a idles alongside), then check b against given values.
  task automatic cyc_b(input logic [2:0] s, input logic l, input int exp_wc, input logic exp_err);
    logic [31:0] r;
    logic [3:0]  ey;
    r = $urandom;
    ey = (s >= 3'd6) ? r[3:0] : r[int'(s)*4 +: 4];
    ib.sel = s; ib.d = r[23:0]; ib.in_valid = 1'b1; ib.in_last = l;
    cyc(3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    ib.in_valid = 1'b0;
    chk("b_y",          {28'd0, ib.y},          {28'd0, ey});
    chk("b_word_count", {30'd0, ib.word_count}, exp_wc);
    chk("b_sel_err",    {31'd0, ib.sel_err},    {31'd0, exp_err});
  endtask

  initial begin
    logic [31:0] r;
    model_reset();
    ia.sel = 0; ia.d = 0; ia.in_valid = 0; ia.in_last = 0; ia.out_ready = 1;
    ib.sel = 0; ib.d = 0; ib.in_valid = 0; ib.in_last = 0; ib.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid",  {31'd0, ia.out_valid},  32'd0);
    chk("rst_word_count", {24'd0, ia.word_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-beat frame, then a 3-beat frame (ch1=3, ch5=1, ch7=F).
    tbl[0] = '{3'd3, 4'hB, 1'b1, 4'hB, 1'b1 ^ ODD, 1'b1 ^ ODD, 1};
    tbl[1] = '{3'd1, 4'h3, 1'b0, 4'h3, 1'b0 ^ ODD, 1'b0 ^ ODD, 1};
    tbl[2] = '{3'd5, 4'h1, 1'b0, 4'h1, 1'b1 ^ ODD, 1'b1 ^ ODD, 2};
    tbl[3] = '{3'd7, 4'hF, 1'b1, 4'hF, 1'b0 ^ ODD, 1'b1 ^ ODD, 3};
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      r[int'(tbl[i].sel)*4 +: 4] = tbl[i].word;
      cyc(tbl[i].sel, r, 1'b1, tbl[i].last, 1'b1);
      chk("tbl_y",      {28'd0, ia.y},            {28'd0, tbl[i].y});
      chk("tbl_yp",     {31'd0, ia.y_parity},     {31'd0, tbl[i].yp});
      chk("tbl_fp",     {31'd0, ia.frame_parity}, {31'd0, tbl[i].fp});
      chk("tbl_wc",     {24'd0, ia.word_count},   tbl[i].wc);
      chk("tbl_last",   {31'd0, ia.out_last},     {31'd0, tbl[i].last});
    end

    // Backpressure: 4 stalled cycles hold the beat, release accepts at once.
    cyc(3'd2, $urandom, 1'b1, 1'b0, 1'b1);
    repeat (4) cyc(3'd4, $urandom, 1'b1, 1'b0, 1'b0);
    cyc(3'd6, $urandom, 1'b1, 1'b1, 1'b1);
    chk("stall_wc", {24'd0, ia.word_count}, 32'd2);
    cyc(3'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Saturating counter and sticky select error on the 6-channel, CNT_W=2 instance.
    cyc_b(3'd1, 1'b0, 1, 1'b0);
    cyc_b(3'd2, 1'b0, 2, 1'b0);
    cyc_b(3'd3, 1'b0, 3, 1'b0);
    cyc_b(3'd4, 1'b0, 3, 1'b0);
    cyc_b(3'd5, 1'b0, 3, 1'b0);
    cyc_b(3'd0, 1'b1, 3, 1'b0);
    cyc_b(3'd7, 1'b1, 1, 1'b1);
    cyc_b(3'd2, 1'b1, 1, 1'b1);

    // Reset mid-frame clears asynchronously and discards the frame.
    cyc(3'd1, $urandom, 1'b1, 1'b0, 1'b1);
    cyc(3'd2, $urandom, 1'b1, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid",    {31'd0, ia.out_valid},    32'd0);
    chk("arst_y",            {28'd0, ia.y},            32'd0);
    chk("arst_frame_parity", {31'd0, ia.frame_parity}, 32'd0);
    chk("arst_word_count",   {24'd0, ia.word_count},   32'd0);
    chk("arst_b_sel_err",    {31'd0, ib.sel_err},      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(3'd4, $urandom, 1'b1, 1'b0, 1'b1);
    chk("post_rst_wc", {24'd0, ia.word_count}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
